// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush, hold, optional skid entry
// and a saturating back-pressure counter for stall profiling.
module pipe_stage_buf #(
  parameter int unsigned DATA_W      = 160,
  parameter int unsigned SKID        = 1,
  parameter int unsigned ZERO_BUBBLE = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              hold,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  localparam bit USE_SKID = (SKID != 0);
  localparam bit USE_ZB   = (ZERO_BUBBLE != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] m_data, m_nx;
  logic [DATA_W-1:0] s_data, s_nx;
  logic              frozen;
  logic              accept;
  logic              emit;

  // Flush outranks hold, so a flushing stage keeps its handshake outputs live.
  assign frozen = hold & ~flush;

  // With a skid entry, in_ready depends only on registered state, never on out_ready.
  always_comb begin
    in_ready = 1'b0;
    if (reset_n && !frozen) begin
      if (USE_SKID) in_ready = (state != FULL);
      else          in_ready = (state == EMPTY) | out_ready;
    end
  end

  assign out_valid = (state != EMPTY) & ~frozen;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign out_data  = (USE_ZB && !out_valid) ? '0 : m_data;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    m_nx     = m_data;
    s_nx     = s_data;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx = ONE;
            m_nx     = in_data;
          end
        end
        ONE: begin
          if (accept && emit) begin
            m_nx = in_data;
          end else if (accept && USE_SKID) begin
            state_nx = FULL;
            s_nx     = in_data;
          end else if (emit) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_nx = ONE;
            m_nx     = s_data;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= EMPTY;
      m_data    <= '0;
      s_data    <= '0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nx;
      m_data <= m_nx;
      s_data <= s_nx;
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid/zero-bubble instance and a single-entry/hold-data
// instance share stimulus and are compared every cycle against a FIFO-level model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        flush;
  logic        hold;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [15:0] out_data_a, out_data_b;
  logic [3:0]  stall_a;
  logic [5:0]  stall_b;
  logic [1:0]  occ_a, occ_b;

  int checks   = 0;
  int failures = 0;

  localparam int SKID_M [2] = '{1, 0};
  localparam int ZB_M   [2] = '{1, 0};
  localparam int SMAX   [2] = '{15, 63};

  logic [15:0] fifo   [2][2];
  int          fcnt   [2];
  logic [15:0] last_m [2];
  int          stall_m[2];
  logic        exp_ir [2];
  logic        exp_ov [2];
  logic [15:0] exp_od [2];
  bit          chk_en = 1'b0;

  pipe_stage_buf #(.DATA_W(16), .SKID(1), .ZERO_BUBBLE(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .flush(flush), .hold(hold), .stall_cnt(stall_a),
    .occupancy(occ_a)
  );

  pipe_stage_buf #(.DATA_W(16), .SKID(0), .ZERO_BUBBLE(0), .CNT_W(6)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .flush(flush), .hold(hold), .stall_cnt(stall_b),
    .occupancy(occ_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, compare both instances mid-cycle, then advance the model.
  task automatic applyStimulus(input logic iv, input logic [15:0] data, input logic ordy,
                               input logic fl, input logic hd, input logic rn);
    logic acc [2];
    logic emt [2];
    logic frozen;
    in_valid  = iv;
    in_data   = data;
    out_ready = ordy;
    flush     = fl;
    hold      = hd;
    reset_n   = rn;
    @(negedge clk);
    frozen = hd & ~fl;
    for (int k = 0; k < 2; k++) begin
      exp_ir[k] = rn && !frozen && ((SKID_M[k] != 0) ? (fcnt[k] < 2) : (fcnt[k] == 0 || ordy));
      exp_ov[k] = !frozen && (fcnt[k] > 0);
      exp_od[k] = exp_ov[k] ? fifo[k][0] : ((ZB_M[k] != 0) ? 16'h0 : last_m[k]);
      acc[k]    = iv & exp_ir[k];
      emt[k]    = exp_ov[k] & ordy;
    end
    if (chk_en) begin
      checkOutput("a.in_ready",  64'(in_ready_a),  64'(exp_ir[0]));
      checkOutput("a.out_valid", 64'(out_valid_a), 64'(exp_ov[0]));
      checkOutput("a.out_data",  64'(out_data_a),  64'(exp_od[0]));
      checkOutput("a.occupancy", 64'(occ_a),       64'(fcnt[0]));
      checkOutput("a.stall_cnt", 64'(stall_a),     64'(stall_m[0]));
      checkOutput("b.in_ready",  64'(in_ready_b),  64'(exp_ir[1]));
      checkOutput("b.out_valid", 64'(out_valid_b), 64'(exp_ov[1]));
      checkOutput("b.out_data",  64'(out_data_b),  64'(exp_od[1]));
      checkOutput("b.occupancy", 64'(occ_b),       64'(fcnt[1]));
      checkOutput("b.stall_cnt", 64'(stall_b),     64'(stall_m[1]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        fcnt[k]    = 0;
        stall_m[k] = 0;
        last_m[k]  = 16'h0;
      end else begin
        if (exp_ov[k] && !ordy && stall_m[k] < SMAX[k]) stall_m[k]++;
        if (fl) begin
          fcnt[k] = 0;
        end else begin
          if (emt[k]) begin
            fifo[k][0] = fifo[k][1];
            fcnt[k]--;
          end
          if (acc[k] && fcnt[k] < 2) begin
            fifo[k][fcnt[k]] = data;
            fcnt[k]++;
          end
        end
        if (fcnt[k] > 0) last_m[k] = fifo[k][0];
      end
    end
    #1;
  endtask

  initial begin
    int s0;
    for (int k = 0; k < 2; k++) begin
      fcnt[k]    = 0;
      stall_m[k] = 0;
      last_m[k]  = 16'h0;
      fifo[k][0] = 16'h0;
      fifo[k][1] = 16'h0;
    end
    reset_n = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    out_ready = 1'b0; flush = 1'b0; hold = 1'b0;

    // reset with a payload offered
    applyStimulus(1'b1, 16'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    applyStimulus(1'b1, 16'hAB, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.out_valid", 64'(out_valid_a), 64'd0);
    checkOutput("rst.out_data",  64'(out_data_a),  64'd0);
    checkOutput("rst.occupancy", 64'(occ_a),       64'd0);
    checkOutput("rst.stall_cnt", 64'(stall_a),     64'd0);
    checkOutput("rst.in_ready",  64'(in_ready_a),  64'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rel.in_ready", 64'(in_ready_a), 64'd1);

    // back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput("stream.out_data",  64'(out_data_a), 64'(i));
      checkOutput("stream.occupancy", 64'(occ_a),      64'd1);
    end
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("stream.drained", 64'(occ_a), 64'd0);

    // back-pressure fills main and skid entries
    applyStimulus(1'b1, 16'h10, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.occupancy", 64'(occ_a),      64'd2);
    checkOutput("bp.in_ready",  64'(in_ready_a), 64'd0);
    applyStimulus(1'b1, 16'h12, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.head", 64'(out_data_a), 64'h10);
    applyStimulus(1'b1, 16'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.second", 64'(out_data_a), 64'h11);
    applyStimulus(1'b1, 16'h12, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.third", 64'(out_data_a), 64'h12);
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("bp.stall_cnt", 64'(stall_a), 64'd2);

    // flush while full
    applyStimulus(1'b1, 16'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h31, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("fl.full", 64'(occ_a), 64'd2);
    applyStimulus(1'b1, 16'h55, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("fl.occupancy", 64'(occ_a),       64'd0);
    checkOutput("fl.out_valid", 64'(out_valid_a), 64'd0);
    checkOutput("fl.out_data",  64'(out_data_a),  64'd0);
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // hold freezes a single held payload
    applyStimulus(1'b1, 16'h77, 1'b1, 1'b0, 1'b0, 1'b1);
    s0 = int'(stall_a);
    repeat (3) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("hold.out_valid", 64'(out_valid_a), 64'd0);
      checkOutput("hold.in_ready",  64'(in_ready_a),  64'd0);
      checkOutput("hold.stall_cnt", 64'(stall_a),     64'(s0));
    end
    hold = 1'b0;
    #1;
    checkOutput("hold.resume_valid", 64'(out_valid_a), 64'd1);
    checkOutput("hold.resume_data",  64'(out_data_a),  64'h77);
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // counter saturation, then combinational ready of the single-entry stage
    applyStimulus(1'b1, 16'h90, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sat.stall_cnt", 64'(stall_a), 64'd15);
    checkOutput("sat.b_occ",     64'(occ_b),   64'd1);
    in_valid = 1'b1; in_data = 16'h91; out_ready = 1'b0;
    #1;
    checkOutput("flow.ready_low", 64'(in_ready_b), 64'd0);
    out_ready = 1'b1;
    #1;
    checkOutput("flow.ready_high", 64'(in_ready_b), 64'd1);
    applyStimulus(1'b1, 16'h91, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("flow.reload", 64'(out_data_b), 64'h91);
    repeat (2) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0,
                    ($urandom % 25) == 0, ($urandom % 12) == 0, ($urandom % 80) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
